// File: rtl/comparator_stimulus_sequencer.sv
// -----------------------------------------------------------------------------
// comparator_stimulus_sequencer
//
// Purpose:
//   Exhaustive self-test driver for a 6-input, 3-bit equality comparator
//   (FI = 1 iff {A,B,C} == {D,E,F}). A start pulse runs a sweep over all 64
//   input combinations. Each vector is held for SETTLE_CYCLES cycles and then
//   FI is sampled for one cycle and compared with the expected equality.
//   Match/error counts, the first failing vector and a pass verdict are
//   reported when the sweep completes.
//
// Parameters:
//   SETTLE_CYCLES   cycles A..F are held before FI is sampled (1..15)
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   one-cycle sweep request, ignored while busy
//   FI              in   comparator result for the driven A..F
//   A,B,C           out  first operand, A = MSB
//   D,E,F           out  second operand, D = MSB
//   busy            out  sweep in progress
//   done            out  sweep finished, results valid until next start
//   pass            out  err_count == 0 and match_count == 8 (valid with done)
//   match_count     out  vectors where sampled FI = 1
//   err_count       out  vectors where sampled FI differs from expected
//   first_err_vec   out  {A,B,C,D,E,F} of the first mismatch
//   first_err_valid out  first_err_vec holds a captured value
//   dbg_state       out  current FSM state (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
// -----------------------------------------------------------------------------
module comparator_stimulus_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       FI,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] match_count,
    output logic [6:0] err_count,
    output logic [5:0] first_err_vec,
    output logic       first_err_valid,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Settle counter counts SETTLE_CYCLES-1 down to 0, giving exactly
    // SETTLE_CYCLES cycles in SETTLE before the sample cycle.
    localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_vec;
    logic [3:0] r_settle_cnt;
    logic [6:0] r_match_cnt;
    logic [6:0] r_err_cnt;
    logic [5:0] r_first_vec;
    logic       r_first_valid;

    logic       w_exp;
    logic       w_mismatch;
    logic       w_start_run;
    logic       w_last_vec;

    assign w_exp       = (r_vec[5:3] == r_vec[2:0]);
    assign w_mismatch  = (FI != w_exp);
    assign w_last_vec  = (r_vec == 6'd63);
    // A start is honoured only when no sweep is running.
    assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == 4'd0) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: w_state_nxt = w_last_vec ? ST_DONE : ST_SETTLE;
            ST_DONE:   if (start) w_state_nxt = ST_SETTLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: vector, settle counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec         <= 6'd0;
            r_settle_cnt  <= 4'd0;
            r_match_cnt   <= 7'd0;
            r_err_cnt     <= 7'd0;
            r_first_vec   <= 6'd0;
            r_first_valid <= 1'b0;
        end else if (w_start_run) begin
            r_vec         <= 6'd0;
            r_settle_cnt  <= LP_SETTLE_LOAD;
            r_match_cnt   <= 7'd0;
            r_err_cnt     <= 7'd0;
            r_first_vec   <= 6'd0;
            r_first_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_settle_cnt != 4'd0) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (FI) begin
                        r_match_cnt <= r_match_cnt + 7'd1;
                    end
                    if (w_mismatch) begin
                        r_err_cnt <= r_err_cnt + 7'd1;
                        if (!r_first_valid) begin
                            r_first_vec   <= r_vec;
                            r_first_valid <= 1'b1;
                        end
                    end
                    // Vector 63 is held through DONE; the sweep never wraps.
                    if (!w_last_vec) begin
                        r_vec        <= r_vec + 6'd1;
                        r_settle_cnt <= LP_SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {A, B, C, D, E, F} = r_vec;
    assign busy            = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done            = (r_state == ST_DONE);
    // Counts are final once DONE is entered, so the verdict is a pure decode.
    assign pass            = done && (r_err_cnt == 7'd0) && (r_match_cnt == 7'd8);
    assign match_count     = r_match_cnt;
    assign err_count       = r_err_cnt;
    assign first_err_vec   = r_first_vec;
    assign first_err_valid = r_first_valid;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_comparator_stimulus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_comparator_stimulus_sequencer
//
// Directed bench for comparator_stimulus_sequencer. Two instances share clock,
// reset and start: dut0 with SETTLE_CYCLES=2 and dut1 with SETTLE_CYCLES=1.
// Each instance sees FI from a behavioural comparator model whose flavour
// (ideal, tied 0, tied 1, ignoring C/F) is selected by model_mode.
// -----------------------------------------------------------------------------
module tb_comparator_stimulus_sequencer;

    localparam int MODE_IDEAL = 0;
    localparam int MODE_TIE0  = 1;
    localparam int MODE_TIE1  = 2;
    localparam int MODE_FAULT = 3;
    localparam int TIMEOUT    = 400;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic start;
    int   model_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       fi0, a0, b0, c0, d0, e0, f0, busy0, done0, pass0, fvalid0;
    logic [6:0] match0, err0;
    logic [5:0] fvec0;
    logic [1:0] state0;

    logic       fi1, a1, b1, c1, d1, e1, f1, busy1, done1, pass1, fvalid1;
    logic [6:0] match1, err1;
    logic [5:0] fvec1;
    logic [1:0] state1;

    function automatic logic model_fi(input int mode, input logic [5:0] v);
        case (mode)
            MODE_TIE0:  return 1'b0;
            MODE_TIE1:  return 1'b1;
            MODE_FAULT: return (v[5:4] == v[2:1]);
            default:    return (v[5:3] == v[2:0]);
        endcase
    endfunction

    assign fi0 = model_fi(model_mode, {a0, b0, c0, d0, e0, f0});
    assign fi1 = model_fi(model_mode, {a1, b1, c1, d1, e1, f1});

    comparator_stimulus_sequencer #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .FI(fi0),
        .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .F(f0),
        .busy(busy0), .done(done0), .pass(pass0),
        .match_count(match0), .err_count(err0),
        .first_err_vec(fvec0), .first_err_valid(fvalid0),
        .dbg_state(state0)
    );

    comparator_stimulus_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .FI(fi1),
        .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1),
        .busy(busy1), .done(done1), .pass(pass1),
        .match_count(match1), .err_count(err1),
        .first_err_vec(fvec1), .first_err_valid(fvalid1),
        .dbg_state(state1)
    );

    // ---------------- scoreboard counters / check ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns at the negedge following the edge that sampled start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until each instance raises done.
    task automatic wait_done(output int lat0, output int lat1);
        lat0 = -1;
        lat1 = -1;
        for (int n = 1; n <= TIMEOUT; n++) begin
            if (done0 && lat0 < 0) lat0 = n;
            if (done1 && lat1 < 0) lat1 = n;
            if (lat0 >= 0 && lat1 >= 0) break;
            @(negedge clk);
        end
    endtask

    task automatic check_started(input string tag);
        check_val({tag, "_busy"}, int'(busy0), 1);
        check_val({tag, "_done"}, int'(done0), 0);
        check_val({tag, "_vec"},  int'({a0, b0, c0, d0, e0, f0}), 0);
        check_val({tag, "_cnt"},  int'({match0, err0}), 0);
        check_val({tag, "_fv"},   int'(fvalid0), 0);
    endtask

    task automatic check_results(input string tag, input int lat0, input int lat1,
                                 input int exp_match, input int exp_err,
                                 input int exp_pass, input int exp_fvalid,
                                 input int exp_fvec);
        check_val({tag, "_lat_s2"},   lat0, 193);
        check_val({tag, "_lat_s1"},   lat1, 129);
        check_val({tag, "_busy"},     int'(busy0), 0);
        check_val({tag, "_match"},    int'(match0), exp_match);
        check_val({tag, "_err"},      int'(err0), exp_err);
        check_val({tag, "_pass"},     int'(pass0), exp_pass);
        check_val({tag, "_fvalid"},   int'(fvalid0), exp_fvalid);
        check_val({tag, "_vec_end"},  int'({a0, b0, c0, d0, e0, f0}), 63);
        check_val({tag, "_match_s1"}, int'(match1), exp_match);
        check_val({tag, "_err_s1"},   int'(err1), exp_err);
        check_val({tag, "_pass_s1"},  int'(pass1), exp_pass);
        if (exp_fvalid != 0) begin
            check_val({tag, "_fvec"},    int'(fvec0), exp_fvec);
            check_val({tag, "_fvec_s1"}, int'(fvec1), exp_fvec);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int lat0, lat1;
        rst_n      = 1'b0;
        start      = 1'b0;
        model_mode = MODE_IDEAL;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_vec",    int'({a0, b0, c0, d0, e0, f0}), 0);
        check_val("rst_busy",   int'(busy0), 0);
        check_val("rst_done",   int'(done0), 0);
        check_val("rst_pass",   int'(pass0), 0);
        check_val("rst_counts", int'({match0, err0}), 0);
        check_val("rst_first",  int'({fvalid0, fvec0}), 0);
        check_val("rst_state",  int'(state0), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: ideal comparator
        pulse_start();
        check_started("t1_start");
        wait_done(lat0, lat1);
        check_results("t1", lat0, lat1, 8, 0, 1, 0, 0);

        // 2: FI tied 0
        model_mode = MODE_TIE0;
        pulse_start();
        wait_done(lat0, lat1);
        check_results("t2", lat0, lat1, 0, 8, 0, 1, 6'b000000);

        // 6: restart from DONE with an ideal comparator
        model_mode = MODE_IDEAL;
        pulse_start();
        check_started("t6_restart");
        wait_done(lat0, lat1);
        check_results("t6", lat0, lat1, 8, 0, 1, 0, 0);

        // 3: FI tied 1
        model_mode = MODE_TIE1;
        pulse_start();
        wait_done(lat0, lat1);
        check_results("t3", lat0, lat1, 64, 56, 0, 1, 6'b000001);

        // 4: comparator ignoring C and F
        model_mode = MODE_FAULT;
        pulse_start();
        wait_done(lat0, lat1);
        check_results("t4", lat0, lat1, 16, 8, 0, 1, 6'b000001);

        // 5a: start re-pulsed while vector 10 is driven (cycles t+31..t+33)
        model_mode = MODE_IDEAL;
        pulse_start();
        repeat (30) @(negedge clk);
        check_val("t5_vec10", int'({a0, b0, c0, d0, e0, f0}), 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("t5_still_busy", int'(busy0), 1);
        wait_done(lat0, lat1);
        // 32 edges already elapsed before wait_done began counting at 1.
        if (lat0 >= 0) lat0 = lat0 + 31;
        if (lat1 >= 0) lat1 = lat1 + 31;
        check_results("t5a", lat0, lat1, 8, 0, 1, 0, 0);

        // 5b: reset during vector 20 (cycles t+61..t+63)
        pulse_start();
        repeat (61) @(negedge clk);
        check_val("t5_vec20", int'({a0, b0, c0, d0, e0, f0}), 20);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_rst_vec",    int'({a0, b0, c0, d0, e0, f0}), 0);
        check_val("t5_rst_busy",   int'(busy0), 0);
        check_val("t5_rst_counts", int'({match0, err0}), 0);
        check_val("t5_rst_done",   int'(done0), 0);
        check_val("t5_rst_first",  int'(fvalid0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 5c: fresh sweep after reset
        pulse_start();
        check_started("t5c_start");
        wait_done(lat0, lat1);
        check_results("t5c", lat0, lat1, 8, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
